spi_slave_param: RTL and testbench

Parametrised SPI slave for the serial peripheral subsystem. It carries configurable word width, all four SPI modes (CPOL/CPHA) and MSB- or LSB-first ordering. Asynchronous pins pass through synchronisers. Transmit data is taken through a one-word ready/valid buffer, and received words are presented with a one-cycle valid strobe. Chip select stays low across back-to-back words, and sticky error flags report underrun and aborted frames.

---
 rtl/spi_slave_param.sv | 170 +++++++++++++++++
 tb/tb_spi_slave_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: synchronised pins, one-word transmit buffer,
// word-strobed receive path and sticky underrun/abort flags.
`timescale 1ns/1ps
module spi_slave_param #(
    parameter int DATA_W      = 12,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun,
    output logic              abort,
    input  logic              err_clr
);
    // state  | meaning
    // IDLE   | deselected; sclk edges ignored, miso driven low
    // ACTIVE | cs_n low; sampling, shifting and word loads enabled

    localparam int   CNT_W    = $clog2(DATA_W);
    localparam logic CPOL_LVL = (CPOL != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
    logic load, do_sample, do_shift, end_frame, hs, out_bit;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh, tx_shifted, buf_data, rx_next;
    logic [DATA_W-2:0] rx_sh, rx_keep;
    logic              buf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL_LVL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= CPOL_LVL;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign lead_edge   = (sclk_s != sclk_d) && (sclk_d == CPOL_LVL);
    assign trail_edge  = (sclk_s != sclk_d) && (sclk_s == CPOL_LVL);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign cs_fall     = cs_d && !cs_s;
    assign cs_rise     = !cs_d && cs_s;

    assign busy     = !cs_s;
    assign tx_ready = !buf_full;
    assign hs       = tx_valid && !buf_full;

    if (MSB_FIRST != 0) begin : g_msb
        assign out_bit    = tx_sh[DATA_W-1];
        assign tx_shifted = tx_sh << 1;
        assign rx_next    = {rx_sh, mosi_s};
        assign rx_keep    = rx_next[DATA_W-2:0];
    end else begin : g_lsb
        assign out_bit    = tx_sh[0];
        assign tx_shifted = tx_sh >> 1;
        assign rx_next    = {mosi_s, rx_sh};
        assign rx_keep    = rx_next[DATA_W-1:1];
    end

    // A shift edge at bit count 0 is the first shift of a word (CPHA=1) or the
    // one following a word's final sample (CPHA=0): both reload the register.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        end_frame = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    load    = (CPHA == 0);
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    end_frame = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    if (shift_edge) begin
                        if (bit_cnt == '0) load = 1'b1;
                        else               do_shift = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            miso     <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_valid <= 1'b0;
            miso     <= (state_q == ACTIVE) && out_bit;

            if (load) begin
                tx_sh    <= buf_full ? buf_data : '0;
                buf_full <= hs;
            end else if (hs) begin
                buf_full <= 1'b1;
            end
            if (hs) buf_data <= tx_data;
            if (do_shift) tx_sh <= tx_shifted;

            if (end_frame) begin
                tx_sh   <= '0;
                bit_cnt <= '0;
            end
            if (do_sample) begin
                rx_sh <= rx_keep;
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (err_clr)                    underrun <= 1'b0;
            else if (load && !buf_full)     underrun <= 1'b1;
            if (err_clr)                    abort <= 1'b0;
            else if (end_frame && bit_cnt != '0) abort <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: four instances cover every CPOL/CPHA mode and both
// bit orders; a bit-level SPI master exchanges words and checks both directions.
`timescale 1ns/1ps
module tb_spi_slave_param;
    localparam int N  = 4;
    localparam int W  = 12;
    localparam int HP = 8;
    localparam logic [N-1:0] CPOL_M = 4'b1100;
    localparam logic [N-1:0] CPHA_M = 4'b1010;
    localparam logic [N-1:0] MSB_M  = 4'b1001;

    logic clk, rst_n;
    logic sclk [N];
    logic cs_n [N];
    logic mosi [N];
    logic miso [N];
    logic tx_valid [N];
    logic tx_ready [N];
    logic rx_valid [N];
    logic busy [N];
    logic underrun [N];
    logic abort [N];
    logic err_clr [N];
    logic [W-1:0] tx_data [N];
    logic [W-1:0] rx_data [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_slave_param #(
            .DATA_W(W), .CPOL(int'(CPOL_M[g])), .CPHA(int'(CPHA_M[g])),
            .MSB_FIRST(int'(MSB_M[g])), .SYNC_STAGES(g >= 2 ? 3 : 2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi[g]),
            .miso(miso[g]), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
            .busy(busy[g]), .underrun(underrun[g]), .abort(abort[g]), .err_clr(err_clr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rx_cnt [N] = '{default: 0};
    logic [2*W-1:0] rx_hist [N] = '{default: '0};
    logic [W-1:0] last_rx [N] = '{default: '0};

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rx_valid[k]) begin
                rx_cnt[k]  <= rx_cnt[k] + 1;
                rx_hist[k] <= {rx_hist[k][W-1:0], rx_data[k]};
            end
        end
    end

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [inst %0d]: got %0h, expected %0h", name, i, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [W-1:0] v);
        int n;
        n = 0;
        tx_data[i]  = v;
        tx_valid[i] = 1'b1;
        while (!tx_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", i, 32'(n < 200), 32'd1);
        @(negedge clk);
        tx_valid[i] = 1'b0;
    endtask

    // Bit-level master: drives mosi on its shift edge, captures miso just before
    // the sample edge, and reports underrun as seen at the last sample point.
    task automatic xfer(input int i, input int nbits, input logic [2*W-1:0] mw,
                        input int refill_bit, input logic [W-1:0] refill,
                        output logic [2*W-1:0] sw, output logic urun_mid);
        logic cpol, cpha, msb;
        int idx;
        cpol = CPOL_M[i];
        cpha = CPHA_M[i];
        msb  = MSB_M[i];
        sw = '0;
        urun_mid = 1'b0;
        err_clr[i] = 1'b1;
        @(negedge clk);
        err_clr[i] = 1'b0;
        cs_n[i] = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            idx = (b / W) * W + (msb ? (W - 1 - b % W) : (b % W));
            if (!cpha) begin
                mosi[i] = mw[idx];
                repeat (HP) @(negedge clk);
                sw[idx] = miso[i];
                if (b == nbits - 1) urun_mid = underrun[i];
                sclk[i] = ~cpol;
                if (b == refill_bit) push(i, refill);
                repeat (HP) @(negedge clk);
                sclk[i] = cpol;
            end else begin
                repeat (HP) @(negedge clk);
                sclk[i] = ~cpol;
                mosi[i] = mw[idx];
                if (b == refill_bit) push(i, refill);
                repeat (HP) @(negedge clk);
                sw[idx] = miso[i];
                if (b == nbits - 1) urun_mid = underrun[i];
                sclk[i] = cpol;
            end
        end
        repeat (HP) @(negedge clk);
        cs_n[i] = 1'b1;
        repeat (3 * HP) @(negedge clk);
    endtask

    // Reference: miso carries the pushed words in push order (zeros when the
    // buffer was empty), the slave receives the master's words, one strobe each.
    task automatic run_frame(input int i, input int nw, input logic [2*W-1:0] m,
                             input bit fill0, input logic [W-1:0] t0,
                             input bit fill1, input logic [W-1:0] t1);
        int c0;
        logic [2*W-1:0] sw;
        logic um;
        c0 = rx_cnt[i];
        if (fill0) begin
            push(i, t0);
            check("tx_ready_after_hs", i, 32'(tx_ready[i]), 32'd0);
        end
        xfer(i, nw * W, m, (nw == 2 && fill1) ? 4 : -1, t1, sw, um);
        check("miso_word0", i, 32'(sw[W-1:0]), 32'(fill0 ? t0 : '0));
        if (nw == 2) begin
            check("miso_word1", i, 32'(sw[2*W-1:W]), 32'(fill1 ? t1 : '0));
            check("rx_first", i, 32'(rx_hist[i][2*W-1:W]), 32'(m[W-1:0]));
        end
        check("rx_pulses", i, 32'(rx_cnt[i] - c0), 32'(nw));
        check("rx_last", i, 32'(rx_hist[i][W-1:0]), 32'(m[(nw-1)*W +: W]));
        check("underrun_mid", i, 32'(um), 32'(!fill0 || (nw == 2 && !fill1)));
        check("tx_ready_end", i, 32'(tx_ready[i]), 32'd1);
        check("abort_clear", i, 32'(abort[i]), 32'd0);
        last_rx[i] = m[(nw-1)*W +: W];
    endtask

    typedef struct {
        int           inst;
        logic [W-1:0] tx;
        logic [W-1:0] mw;
        logic [W-1:0] exp_miso;
        logic [W-1:0] exp_rx;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, c0, nw;
        logic [2*W-1:0] sw, m;
        logic um;
        logic [W-1:0] t0, t1;
        bit f0;

        vecs[0] = '{0, 12'hA5C, 12'h3F1, 12'hA5C, 12'h3F1};
        vecs[1] = '{0, 12'h801, 12'h801, 12'h801, 12'h801};
        vecs[2] = '{1, 12'h801, 12'h801, 12'h801, 12'h801};
        vecs[3] = '{2, 12'h801, 12'h801, 12'h801, 12'h801};
        vecs[4] = '{3, 12'h801, 12'h801, 12'h801, 12'h801};
        vecs[5] = '{1, 12'h0F0, 12'hC33, 12'h0F0, 12'hC33};
        vecs[6] = '{2, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
        vecs[7] = '{3, 12'h001, 12'h800, 12'h001, 12'h800};

        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            sclk[k] = CPOL_M[k];
            cs_n[k] = 1'b1;
            mosi[k] = 1'b0;
            tx_valid[k] = 1'b0;
            tx_data[k] = '0;
            err_clr[k] = 1'b0;
        end
        repeat (5) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_miso", k, 32'(miso[k]), 32'd0);
            check("rst_tx_ready", k, 32'(tx_ready[k]), 32'd1);
            check("rst_rx_data", k, 32'(rx_data[k]), 32'd0);
            check("rst_rx_valid", k, 32'(rx_valid[k]), 32'd0);
            check("rst_busy", k, 32'(busy[k]), 32'd0);
            check("rst_underrun", k, 32'(underrun[k]), 32'd0);
            check("rst_abort", k, 32'(abort[k]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            i  = vecs[v].inst;
            c0 = rx_cnt[i];
            push(i, vecs[v].tx);
            check("tbl_tx_ready_hs", i, 32'(tx_ready[i]), 32'd0);
            xfer(i, W, {{W{1'b0}}, vecs[v].mw}, -1, '0, sw, um);
            check("tbl_miso", i, 32'(sw[W-1:0]), 32'(vecs[v].exp_miso));
            check("tbl_rx", i, 32'(rx_hist[i][W-1:0]), 32'(vecs[v].exp_rx));
            check("tbl_rx_pulses", i, 32'(rx_cnt[i] - c0), 32'd1);
            check("tbl_underrun", i, 32'(um), 32'd0);
            check("tbl_tx_ready_end", i, 32'(tx_ready[i]), 32'd1);
            last_rx[i] = vecs[v].exp_rx;
        end

        run_frame(0, 2, {12'h9C3, 12'h5A6}, 1'b1, 12'hFED, 1'b1, 12'h123);
        run_frame(3, 2, {12'h3E8, 12'hB17}, 1'b1, 12'hFED, 1'b1, 12'h123);

        run_frame(0, 1, 24'h0007E7, 1'b0, '0, 1'b0, '0);
        check("empty_underrun_set", 0, 32'(underrun[0]), 32'd1);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        check("err_clr_underrun", 0, 32'(underrun[0]), 32'd0);
        run_frame(1, 1, 24'h000A3A, 1'b0, '0, 1'b0, '0);

        for (int a = 0; a < 2; a++) begin
            i  = (a == 0) ? 0 : 3;
            c0 = rx_cnt[i];
            push(i, 12'h456);
            xfer(i, 5, 24'h000ABC, -1, '0, sw, um);
            check("abort_flag", i, 32'(abort[i]), 32'd1);
            check("abort_no_rx", i, 32'(rx_cnt[i] - c0), 32'd0);
            check("abort_rx_hold", i, 32'(rx_data[i]), 32'(last_rx[i]));
            check("abort_idle", i, 32'(busy[i]), 32'd0);
            check("abort_miso_low", i, 32'(miso[i]), 32'd0);
            run_frame(i, 1, 24'h0002D4, 1'b1, 12'h9AB, 1'b0, '0);
        end

        for (int r = 0; r < 10; r++) begin
            i  = $urandom_range(0, N - 1);
            nw = $urandom_range(1, 2);
            f0 = 1'($urandom_range(0, 3) != 0);
            t0 = W'($urandom);
            t1 = W'($urandom);
            m  = (2*W)'($urandom);
            run_frame(i, nw, m, f0, t0, 1'b1, t1);
        end

        push(1, 12'h3C3);
        check("pre_rst_tx_ready", 1, 32'(tx_ready[1]), 32'd0);
        cs_n[0] = 1'b0;
        repeat (HP) @(negedge clk);
        check("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
        check("pre_rst_underrun", 0, 32'(underrun[0]), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 0, 32'(busy[0]), 32'd0);
        check("async_rst_underrun", 0, 32'(underrun[0]), 32'd0);
        check("async_rst_rx_data", 0, 32'(rx_data[0]), 32'd0);
        check("async_rst_miso", 0, 32'(miso[0]), 32'd0);
        check("async_rst_rx_valid", 0, 32'(rx_valid[0]), 32'd0);
        check("async_rst_tx_ready", 1, 32'(tx_ready[1]), 32'd1);
        @(negedge clk);
        cs_n[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_frame(0, 1, 24'h0001E2, 1'b1, 12'h6B9, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
